instr_fetch_unit: RTL and testbench

// - Fetch stage ahead of the main control decoder: owns the PC, requests instructions from imem,

---
 rtl/scp_pkg.sv | 25 ++
 rtl/next_pc_logic.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scp_pkg.sv
// Shared constants and types for the single-cycle processor front end:
// branch-control encodings, major opcodes, fetch FSM states, default reset PC.
package scp_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // {is_branch, is_ne}; 2'b01 decodes as "no branch"
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b10;
    localparam logic [1:0] BR_NE   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC resolution for the instruction currently held by the
// fetch unit: jump target, taken branch target, or fall-through PC+4.
module next_pc_logic
    import scp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pcplus4_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [1:0]       branch_i,
    input  logic             jump_i,
    input  logic             zero_i,
    input  logic [WIDTH-1:0] signimm_i,
    output logic [WIDTH-1:0] next_pc_o
);

    logic             taken;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] branch_target;
    logic [5:0]       unused_opcode;

    // The opcode field is decoded elsewhere; only the jump index matters here.
    assign unused_opcode = instr_i[WIDTH-1:WIDTH-6];

    assign taken         = ((branch_i == BR_EQ) && zero_i) || ((branch_i == BR_NE) && !zero_i);
    assign jump_target   = {pcplus4_i[WIDTH-1:28], instr_i[25:0], 2'b00};
    assign branch_target = pcplus4_i + (signimm_i << 2);

    // Priority select: jump beats branch beats sequential.
    always_comb begin
        // NOTE: assigning a default first means every path drives next_pc_o, so no latch is inferred.
        next_pc_o = pcplus4_i;
        if (jump_i) begin
            next_pc_o = jump_target;
        end else if (taken) begin
            next_pc_o = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, holds the
// returned instruction for decode behind a valid/ready handshake and, on
// retire, advances the PC using the decoder's branch/jump controls.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched/perf_stall counters.
module instr_fetch_unit
    import scp_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pcplus4,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic [1:0]       branch,
    input  logic             jump,
    input  logic             zero,
    input  logic [WIDTH-1:0] signimm
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall
`endif
);

    fetch_state_e     state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pcplus4_q;
    logic             valid_q;
    logic             req_q;
    logic [WIDTH-1:0] next_pc_d;
    logic             retire;

    assign retire = (state_q == S_HOLD) && instr_ready;

    next_pc_logic #(
        .WIDTH (WIDTH)
    ) u_next_pc (
        .pcplus4_i (pcplus4_q),
        .instr_i   (instr_q),
        .branch_i  (branch),
        .jump_i    (jump),
        .zero_i    (zero),
        .signimm_i (signimm),
        .next_pc_o (next_pc_d)
    );

    // Fetch FSM with PC register, instruction buffer and registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pcplus4_q <= RESET_PC + WIDTH'(4);
            valid_q   <= 1'b0;
            req_q     <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q   <= imem_rdata;
                        pcplus4_q <= pc_q + WIDTH'(4);
                        valid_q   <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Late acks are ignored here; only the consumer can release the buffer.
                    if (instr_ready) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    valid_q <= 1'b0;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pcplus4     = pcplus4_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Retired-instruction and fetch-stall counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (retire) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((state_q == S_FETCH) && !imem_ack) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver issues imem acks and retire
// handshakes and pushes the expected fetch addresses and held instructions;
// a separate negedge monitor pops and compares whenever the DUT presents them.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic [1:0]  branch = 2'b00;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] signimm = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (RST_PC)
    ) dut (
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
`endif
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .pcplus4      (pcplus4),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch       (branch),
        .jump         (jump),
        .zero         (zero),
        .signimm      (signimm)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pcplus4;
        int          ack_cyc;
    } exp_instr_t;

    exp_instr_t  instr_q[$];
    logic [31:0] addr_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rst_applied = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] model_pc = RST_PC;
    int          exp_fetched = 0;
    int          exp_stall = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_applied <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic finish_tb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Instruction-level semantics of the next PC after retiring the instruction at pc.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic [1:0] br, input logic j, input logic z,
                                             input logic [31:0] simm);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if ((br == 2'b10 && z) || (br == 2'b11 && !z)) return p4 + simm * 32'd4;
        return p4;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard queues away from the active edge.
    initial begin
        logic [31:0] cur_addr;
        exp_instr_t  cur_instr;
        logic        prev_req;
        logic        prev_valid;
        cur_addr   = RST_PC;
        cur_instr  = '{32'h0, 32'h0, 0};
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_applied) begin
                    check("rst_valid",   {31'b0, instr_valid}, 32'd0);
                    check("rst_req",     {31'b0, imem_req},    32'd1);
                    check("rst_addr",    imem_addr,            RST_PC);
                    check("rst_instr",   instr,                32'h0);
                    check("rst_pcplus4", pcplus4,              RST_PC + 32'd4);
                    cur_addr   = RST_PC;
                    prev_req   = 1'b1;
                    prev_valid = 1'b0;
                end else begin
                    check("req_vs_valid", {31'b0, imem_req ^ instr_valid}, 32'd1);
                    if (imem_req) begin
                        if (!prev_req) begin
                            if (addr_q.size() == 0) fail_note("unexpected_fetch");
                            else cur_addr = addr_q.pop_front();
                        end
                        check("imem_addr", imem_addr, cur_addr);
                    end
                    if (instr_valid) begin
                        if (!prev_valid) begin
                            if (instr_q.size() == 0) fail_note("unexpected_valid");
                            else begin
                                cur_instr = instr_q.pop_front();
                                check("valid_latency", 32'(cyc), 32'(cur_instr.ack_cyc));
                            end
                        end
                        check("instr",   instr,   cur_instr.word);
                        check("pcplus4", pcplus4, cur_instr.pcplus4);
                    end
                    prev_req   = imem_req;
                    prev_valid = instr_valid;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for n edges; the caller sets imem_ack for the first edge if it wants a colliding ack.
    task automatic apply_reset(input int n);
        reset       = 1'b1;
        instr_ready = 1'b0;
        addr_q.delete();
        instr_q.delete();
        model_pc    = RST_PC;
        exp_fetched = 0;
        exp_stall   = 0;
        tick();
        imem_ack = 1'b0;
        repeat (n - 1) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic randomize_ctrl();
        branch  = 2'($urandom);
        jump    = 1'($urandom);
        zero    = 1'($urandom);
        signimm = $urandom;
    endtask

    // One complete instruction: wait for request, ack after ack_dly, hold hold_dly, retire.
    task automatic fetch_one(input logic [31:0] word, input int ack_dly, input int hold_dly,
                             input logic [1:0] br, input logic j, input logic z,
                             input logic [31:0] simm);
        exp_instr_t e;
        int k;
        k = 0;
        while (!imem_req && k < 8) begin
            tick();
            k++;
        end
        if (!imem_req) begin
            fail_note("req_timeout");
            finish_tb();
            return;
        end
        imem_ack = 1'b0;
        repeat (ack_dly) begin
            randomize_ctrl();
            exp_stall++;
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        e.word     = word;
        e.pcplus4  = model_pc + 32'd4;
        e.ack_cyc  = cyc + 1;
        instr_q.push_back(e);
        tick();
        repeat (hold_dly) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            randomize_ctrl();
            tick();
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        branch      = br;
        jump        = j;
        zero        = z;
        signimm     = simm;
        model_pc    = ref_next(model_pc, word, br, j, z, simm);
        addr_q.push_back(model_pc);
        exp_fetched++;
        tick();
        instr_ready = 1'b0;
        randomize_ctrl();
    endtask

    initial begin
        #500000;
        fail_note("global_timeout");
        finish_tb();
    end

    initial begin
        apply_reset(3);

        // Sequential stream with immediate ack/ready: 0x0, 0x4, 0x8, then jump to 0x10.
        fetch_one($urandom, 0, 0, 2'b00, 1'b0, 1'b0, 32'd0);
        fetch_one($urandom, 0, 0, 2'b00, 1'b0, 1'b0, 32'd0);
        fetch_one(32'h0800_0004, 0, 0, 2'b00, 1'b1, 1'b0, 32'd0);
        // BEQ taken / not taken from 0x10.
        fetch_one($urandom, 0, 0, 2'b10, 1'b0, 1'b1, 32'd3);
        fetch_one(32'h0800_0004, 0, 0, 2'b00, 1'b1, 1'b0, 32'd0);
        fetch_one($urandom, 0, 0, 2'b10, 1'b0, 1'b0, 32'd3);
        fetch_one(32'h0800_0004, 0, 0, 2'b00, 1'b1, 1'b0, 32'd0);
        // BNE not taken / taken backwards onto itself.
        fetch_one($urandom, 0, 0, 2'b11, 1'b0, 1'b1, 32'd5);
        fetch_one(32'h0800_0004, 0, 0, 2'b00, 1'b1, 1'b0, 32'd0);
        fetch_one($urandom, 0, 1, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF);
        // Long branch to 0x10000000, then jump beats a taken BEQ.
        fetch_one($urandom, 0, 0, 2'b10, 1'b0, 1'b1, 32'h03FF_FFFB);
        fetch_one(32'h0800_0040, 0, 0, 2'b10, 1'b1, 1'b1, 32'd1);
        // Slow memory and slow consumer.
        fetch_one($urandom, 3, 4, 2'b00, 1'b0, 1'b0, 32'd0);

        // Reset collides with an ack while fetching.
        imem_ack = 1'b0;
        exp_stall++;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        apply_reset(2);

        // Wrap: branch back to 0xFFFFFFFC, then sequential to 0x0.
        fetch_one($urandom, 0, 0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFE);
        fetch_one($urandom, 1, 0, 2'b00, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] simm;
            simm = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 127)) - 64) : $urandom;
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      2'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), simm);
        end

        repeat (3) tick();
        check("addr_q_drained",  32'(addr_q.size()),  32'd0);
        check("instr_q_drained", 32'(instr_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(exp_fetched));
        check("perf_stall",   perf_stall,   32'(exp_stall + 3));
`endif
        finish_tb();
    end

endmodule
